// File: rtl/hud_pkg.sv
// Shared widths, IDs and arbiter state encodings for the HUD digit ROM path.
package hud_pkg;

   localparam int DIGIT_W         = 4;
   localparam int COUNT_W         = 8;
   localparam int ROM_LATENCY_DEF = 1;

   localparam logic [COUNT_W-1:0] CONFLICT_MAX = '1;

   typedef enum logic {
      REQ_TIME  = 1'b0,
      REQ_SCORE = 1'b1
   } req_id_e;

   typedef enum logic {
      PRI_TIME  = 1'b0,
      PRI_SCORE = 1'b1
   } pri_state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] number;
      logic [COUNT_W-1:0] count;
   } rom_addr_t;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (v == CONFLICT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hud_tag_pipe.sv
// Owner/valid shift register that follows each granted lookup through the ROM.
module hud_tag_pipe
   import hud_pkg::*;
#(
   parameter int DEPTH = ROM_LATENCY_DEF + 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    flush,
   input  logic    in_vld,
   input  req_id_e in_own,
   output logic    out_vld,
   output req_id_e out_own
);

   logic [DEPTH-1:0] vld_pipe;
   logic [DEPTH-1:0] own_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         own_pipe <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
         own_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         own_pipe[0] <= in_own;
         for (int k = DEPTH - 1; k > 0; k--) begin
            vld_pipe[k] <= vld_pipe[k-1];
            own_pipe[k] <= own_pipe[k-1];
         end
      end
   end

   assign out_vld = vld_pipe[DEPTH-1];
   assign out_own = req_id_e'(own_pipe[DEPTH-1]);

endmodule

// File: rtl/hud_rom_arbiter.sv
// Arbitrates the time and score digit lookups onto one numbers ROM and routes
// the returned pixel back to whichever requester owned the lookup.
module hud_rom_arbiter
   import hud_pkg::*;
#(
   parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
   input  logic               clock_25,
   input  logic               reset,
   input  logic               sync_reset,
   input  logic               req_time,
   input  logic [DIGIT_W-1:0] time_number,
   input  logic [COUNT_W-1:0] time_count,
   input  logic               req_score,
   input  logic [DIGIT_W-1:0] score_number,
   input  logic [COUNT_W-1:0] score_count,
   input  logic               number_pixel,
   output logic               gnt_time,
   output logic               gnt_score,
   output logic [DIGIT_W-1:0] rom_selected_number,
   output logic [COUNT_W-1:0] rom_number_count,
   output logic               time_pixel,
   output logic               time_pixel_valid,
   output logic               score_pixel,
   output logic               score_pixel_valid,
   output logic [COUNT_W-1:0] conflict_count
);

   pri_state_e pri_state;
   rom_addr_t  rom_q;
   logic       tap_vld;
   req_id_e    tap_own;
   logic       any_gnt;
   req_id_e    gnt_own;

   // Grants are gated by both resets so nothing enters the pipe while clearing.
   always_comb begin
      gnt_time  = 1'b0;
      gnt_score = 1'b0;
      if (reset && !sync_reset) begin
         if (req_time && req_score) begin
            gnt_time  = (pri_state == PRI_TIME);
            gnt_score = (pri_state == PRI_SCORE);
         end else begin
            gnt_time  = req_time;
            gnt_score = req_score;
         end
      end
   end

   assign any_gnt = gnt_time | gnt_score;
   assign gnt_own = gnt_score ? REQ_SCORE : REQ_TIME;

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         pri_state <= PRI_TIME;
      end else if (sync_reset) begin
         pri_state <= PRI_TIME;
      end else if (gnt_time) begin
         pri_state <= PRI_SCORE;
      end else if (gnt_score) begin
         pri_state <= PRI_TIME;
      end
   end

   // Digit index goes out untouched; out-of-range digits are the ROM's problem.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         rom_q <= '0;
      end else if (gnt_time) begin
         rom_q <= '{number: time_number, count: time_count};
      end else if (gnt_score) begin
         rom_q <= '{number: score_number, count: score_count};
      end
   end

   assign rom_selected_number = rom_q.number;
   assign rom_number_count    = rom_q.count;

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         conflict_count <= '0;
      end else if (sync_reset) begin
         conflict_count <= '0;
      end else if (req_time && req_score) begin
         conflict_count <= sat_inc(conflict_count);
      end
   end

   hud_tag_pipe #(
      .DEPTH (ROM_LATENCY + 1)
   ) u_tag_pipe (
      .clk     (clock_25),
      .rst_n   (reset),
      .flush   (sync_reset),
      .in_vld  (any_gnt),
      .in_own  (gnt_own),
      .out_vld (tap_vld),
      .out_own (tap_own)
   );

   // The last tag stage lines up with number_pixel; capture it for the owner only.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         time_pixel        <= 1'b0;
         time_pixel_valid  <= 1'b0;
         score_pixel       <= 1'b0;
         score_pixel_valid <= 1'b0;
      end else begin
         time_pixel_valid  <= 1'b0;
         score_pixel_valid <= 1'b0;
         if (!sync_reset && tap_vld) begin
            if (tap_own == REQ_SCORE) begin
               score_pixel       <= number_pixel;
               score_pixel_valid <= 1'b1;
            end else begin
               time_pixel        <= number_pixel;
               time_pixel_valid  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/hud_rom_arbiter.md
HUD_ROM_ARBITER -- requirements
Module: hud_rom_arbiter

Interface
REQ-001 ROM_LATENCY, 1, cycles from ROM address register to number_pixel valid; legal range 1..3.
REQ-002 clock_25  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; reset=0 clears all state.
REQ-004 sync_reset  input  1  synchronous game restart, active-high.
REQ-005 req_time  input  1  time-counter digit lookup request, level, held until granted.
REQ-006 time_number  input  4  digit index for the time request.
REQ-007 time_count  input  8  glyph pixel offset for the time request.
REQ-008 req_score  input  1  score digit lookup request, level, held until granted.
REQ-009 score_number  input  4  digit index for the score request.
REQ-010 score_count  input  8  glyph pixel offset for the score request.
REQ-011 number_pixel  input  1  pixel returned by the numbers ROM.
REQ-012 gnt_time  output  1  combinational grant to the time requester, this cycle.
REQ-013 gnt_score  output  1  combinational grant to the score requester, this cycle.
REQ-014 rom_selected_number  output  4  registered ROM digit address.
REQ-015 rom_number_count  output  8  registered ROM pixel offset.
REQ-016 time_pixel, time_pixel_valid  outputs  1,1  routed pixel and one-cycle valid strobe for time.
REQ-017 score_pixel, score_pixel_valid  outputs  1,1  routed pixel and one-cycle valid strobe for score.
REQ-018 conflict_count  output  8  saturating count of cycles with both requests high.

Function
REQ-019 At most one of gnt_time/gnt_score SHALL be high in any cycle.
REQ-020 Priority SHALL be a 2-state FSM, PRI_TIME and PRI_SCORE; single request granted regardless of state.
REQ-021 Simultaneous requests SHALL grant the requester named by the FSM state.
REQ-022 Any grant to time SHALL move FSM to PRI_SCORE; any grant to score to PRI_TIME; no grant holds state.
REQ-023 On a grant in cycle t, the granted number/count SHALL appear on rom_* outputs in cycle t+1; with no grant rom_* SHALL hold.
REQ-024 An owner tag pipeline of depth ROM_LATENCY+1 SHALL track each grant; number_pixel sampled at end of cycle t+1+ROM_LATENCY.
REQ-025 Owner's pixel output SHALL update and its valid SHALL pulse for one cycle in t+2+ROM_LATENCY (3 cycles at default).
REQ-026 Pixel outputs SHALL hold last value while valid is low; the non-owner's outputs SHALL be unchanged.
REQ-027 Back-to-back grants SHALL sustain one result per cycle with no bubbles.
REQ-028 Both requests held continuously SHALL alternate grants every cycle, time first after reset.
REQ-029 conflict_count SHALL increment on each cycle with req_time and req_score high, saturating at 255.
REQ-030 Digit indices above 9 SHALL be forwarded unchanged; range checking belongs to the ROM.
REQ-031 sync_reset=1 SHALL force grants low that cycle, flush all in-flight tags (no later valid pulses), set PRI_TIME, clear conflict_count.

Reset
REQ-032 reset=0 SHALL asynchronously clear rom_*, pixel outputs, valids, tags and conflict_count to 0 and FSM to PRI_TIME.
REQ-033 Reset asserted mid-transaction SHALL discard it; no valid pulse SHALL follow deassertion.
REQ-034 Grants SHALL be low while reset=0.

Structure
REQ-035 Shared package hud_pkg SHALL hold digit width 4, count width 8, ROM_LATENCY default, requester IDs and FSM state encodings.
REQ-036 Owner/valid shift register SHALL be sub-module hud_tag_pipe, parameterised by depth; arbitration stays in top level.

Verification
REQ-037 Single req_time, number=7, count=0x23, ROM returns 1 -> gnt_time cycle 0, rom_*=7/0x23 cycle 1, time_pixel=1 with valid cycle 3.
REQ-038 Both requests held 6 cycles -> grants T,S,T,S,T,S; valids alternate cycles 3..8; conflict_count=6.
REQ-039 Both requests held 300 cycles -> conflict_count saturates at 255.
REQ-040 sync_reset cycle 1 after grant in cycle 0 -> no valid pulse, conflict_count=0, next tie grants time.
REQ-041 reset=0 pulsed mid-pipeline -> all outputs 0 immediately, no valid after release.
REQ-042 ROM_LATENCY=3, single req_score -> score_pixel_valid exactly in cycle 5.
